// File: rtl/uart_prog_loader.sv
// ----------------------------------------------------------------------------
// uart_prog_loader
//
// Parses program-load frames arriving from uart_rx and writes the payload into
// the 4-bit CPU's instruction memory. The CPU is held halted while a frame is
// being loaded. It is released only after a frame whose checksum is good.
//
// Frame: SYNC_BYTE, LEN, LEN payload bytes (to addresses 0..LEN-1), CHK.
// The frame is good when (LEN + sum(payload) + CHK) mod 256 == 0.
//
// Ports:
//   clk_i              system clock
//   reset_i            asynchronous, active-low reset
//   data_i             received byte, meaningful only while the strobe is high
//   data_valid_strb_i  one-cycle strobe per received byte
//   mem_we_o           instruction memory write enable (one-cycle pulse)
//   mem_addr_o         instruction memory write address
//   mem_data_o         instruction memory write data
//   cpu_halt_o         1 = CPU stalled
//   busy_o             a frame is in progress
//   load_done_strb_o   one-cycle pulse: frame accepted, checksum good
//   load_error_strb_o  one-cycle pulse: frame rejected
// ----------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int          DATA_WIDTH       = 8,
    parameter int          ADDR_WIDTH       = 4,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
    parameter int          TIMEOUT_COUNTS   = 52100,
    parameter int          TIMEOUT_BITWIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_strb_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_halt_o,
    output logic                  busy_o,
    output logic                  load_done_strb_o,
    output logic                  load_error_strb_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    localparam logic [DATA_WIDTH-1:0]       MAX_LEN  = DATA_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [TIMEOUT_BITWIDTH-1:0] TMO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_COUNTS - 1);
    localparam logic [ADDR_WIDTH:0]         IDX_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                      state_q;
    logic [ADDR_WIDTH:0]         len_q;
    logic [ADDR_WIDTH:0]         idx_q;
    logic [DATA_WIDTH-1:0]       acc_q;
    logic [TIMEOUT_BITWIDTH-1:0] tmo_q;
    logic                        mem_we_q;
    logic [ADDR_WIDTH-1:0]       mem_addr_q;
    logic [DATA_WIDTH-1:0]       mem_data_q;
    logic                        halt_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    // Running checksum including the current byte. It is only consulted in
    // the CHK state, where a zero result marks a good frame.
    logic [DATA_WIDTH-1:0] sum_d;
    logic [ADDR_WIDTH:0]   idx_d;

    assign sum_d = acc_q + data_i;
    assign idx_d = idx_q + IDX_ONE;

    // Frame parser. The index is one bit wider than the address so that a
    // full-size program (LEN = 2^ADDR_WIDTH) ends without the address wrapping.
    // A strobe always takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            tmo_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            halt_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            if (state_q == S_IDLE) begin
                tmo_q <= '0;
                if (data_valid_strb_i && (data_i == DATA_WIDTH'(SYNC_BYTE))) begin
                    state_q <= S_LEN;
                    halt_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
            end else if (data_valid_strb_i) begin
                tmo_q <= '0;
                unique case (state_q)
                    S_LEN: begin
                        if ((data_i == '0) || (data_i > MAX_LEN)) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            len_q   <= data_i[ADDR_WIDTH:0];
                            acc_q   <= data_i;
                            idx_q   <= '0;
                            state_q <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= idx_q[ADDR_WIDTH-1:0];
                        mem_data_q <= data_i;
                        acc_q      <= sum_d;
                        idx_q      <= idx_d;
                        if (idx_d == len_q) begin
                            state_q <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (sum_d == '0) begin
                            done_q <= 1'b1;
                            halt_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end else if (tmo_q == TMO_LAST) begin
                tmo_q   <= '0;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_data_o        = mem_data_q;
    assign cpu_halt_o        = halt_q;
    assign busy_o            = busy_q;
    assign load_done_strb_o  = done_q;
    assign load_error_strb_o = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader. Bytes are presented one per cycle and
// outputs are sampled on the falling edge, after the rising edge that
// consumed the byte. The timeout is shortened so silence can be observed
// quickly.
// ----------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int TMO = 40;

    logic       clk;
    logic       resetN;
    logic [7:0] dataIn;
    logic       strobe;
    logic       memWe;
    logic [3:0] memAddr;
    logic [7:0] memData;
    logic       cpuHalt;
    logic       busy;
    logic       loadDone;
    logic       loadError;

    int total = 0;
    int bad   = 0;

    uart_prog_loader #(
        .DATA_WIDTH       (8),
        .ADDR_WIDTH       (4),
        .SYNC_BYTE        (8'hA5),
        .TIMEOUT_COUNTS   (TMO),
        .TIMEOUT_BITWIDTH (16)
    ) dut (
        .clk_i             (clk),
        .reset_i           (resetN),
        .data_i            (dataIn),
        .data_valid_strb_i (strobe),
        .mem_we_o          (memWe),
        .mem_addr_o        (memAddr),
        .mem_data_o        (memData),
        .cpu_halt_o        (cpuHalt),
        .busy_o            (busy),
        .load_done_strb_o  (loadDone),
        .load_error_strb_o (loadError)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one byte with a one-cycle strobe; returns on the falling edge
    // after the consuming rising edge, when its effects are visible.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        dataIn = b;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        dataIn = 8'h00;
    endtask

    // Payload byte: must produce a write pulse at the expected address.
    task automatic sendPayload(input string tag, input logic [7:0] b,
                               input logic [3:0] addr);
        applyStimulus(b);
        checkOutput({tag, " we"}, 32'(memWe), 32'd1);
        checkOutput({tag, " addr"}, 32'(memAddr), 32'(addr));
        checkOutput({tag, " data"}, 32'(memData), 32'(b));
    endtask

    // The reference good frame: A5 03 12 34 56 61, releases the CPU.
    task automatic sendGoodFrame(input string tag);
        applyStimulus(8'hA5);
        checkOutput({tag, " busy after sync"}, 32'(busy), 32'd1);
        checkOutput({tag, " halt after sync"}, 32'(cpuHalt), 32'd1);
        applyStimulus(8'h03);
        checkOutput({tag, " no write on len"}, 32'(memWe), 32'd0);
        sendPayload({tag, " w0"}, 8'h12, 4'h0);
        sendPayload({tag, " w1"}, 8'h34, 4'h1);
        sendPayload({tag, " w2"}, 8'h56, 4'h2);
        applyStimulus(8'h61);
        checkOutput({tag, " done"}, 32'(loadDone), 32'd1);
        checkOutput({tag, " no error"}, 32'(loadError), 32'd0);
        checkOutput({tag, " halt released"}, 32'(cpuHalt), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done one cycle"}, 32'(loadDone), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int errCycle;

        resetN = 1'b0;
        strobe = 1'b0;
        dataIn = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values.
        checkOutput("reset halt", 32'(cpuHalt), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset we", 32'(memWe), 32'd0);
        checkOutput("reset addr", 32'(memAddr), 32'd0);
        checkOutput("reset data", 32'(memData), 32'd0);
        checkOutput("reset done", 32'(loadDone), 32'd0);
        checkOutput("reset error", 32'(loadError), 32'd0);
        resetN = 1'b1;

        // Good frame, plus write-pulse width and hold behaviour.
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        sendPayload("good w0", 8'h12, 4'h0);
        @(negedge clk);
        checkOutput("we single cycle", 32'(memWe), 32'd0);
        checkOutput("addr holds", 32'(memAddr), 32'd0);
        checkOutput("data holds", 32'(memData), 32'h12);
        sendPayload("good w1", 8'h34, 4'h1);
        sendPayload("good w2", 8'h56, 4'h2);
        applyStimulus(8'h61);
        checkOutput("good done", 32'(loadDone), 32'd1);
        checkOutput("good halt", 32'(cpuHalt), 32'd0);
        @(negedge clk);
        checkOutput("good done pulse", 32'(loadDone), 32'd0);
        checkOutput("good idle", 32'(busy), 32'd0);

        // Bad checksum: sync re-halts the CPU, writes still happen.
        applyStimulus(8'hA5);
        checkOutput("bad halt on sync", 32'(cpuHalt), 32'd1);
        applyStimulus(8'h03);
        sendPayload("bad w0", 8'h12, 4'h0);
        sendPayload("bad w1", 8'h34, 4'h1);
        sendPayload("bad w2", 8'h56, 4'h2);
        applyStimulus(8'h62);
        checkOutput("bad error", 32'(loadError), 32'd1);
        checkOutput("bad no done", 32'(loadDone), 32'd0);
        checkOutput("bad halt", 32'(cpuHalt), 32'd1);
        @(negedge clk);
        checkOutput("bad error pulse", 32'(loadError), 32'd0);
        checkOutput("bad idle", 32'(busy), 32'd0);

        // Garbage before sync is ignored, sync inside the frame is data.
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h5A);
        checkOutput("garbage idle", 32'(busy), 32'd0);
        checkOutput("garbage no write", 32'(memWe), 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        sendPayload("insync w0", 8'hA5, 4'h0);
        sendPayload("insync w1", 8'h01, 4'h1);
        applyStimulus(8'h58);
        checkOutput("insync done", 32'(loadDone), 32'd1);
        checkOutput("insync halt", 32'(cpuHalt), 32'd0);

        // Length bounds: zero and one past the maximum.
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        checkOutput("len0 error", 32'(loadError), 32'd1);
        checkOutput("len0 no write", 32'(memWe), 32'd0);
        checkOutput("len0 idle", 32'(busy), 32'd0);
        checkOutput("len0 halt", 32'(cpuHalt), 32'd1);
        applyStimulus(8'hA5);
        applyStimulus(8'h11);
        checkOutput("len17 error", 32'(loadError), 32'd1);
        checkOutput("len17 no write", 32'(memWe), 32'd0);
        checkOutput("len17 idle", 32'(busy), 32'd0);

        // Maximum length: 16 words, addresses 0..F, no wrap.
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        for (int i = 0; i < 16; i++) begin
            sendPayload($sformatf("max w%0d", i), 8'(i), 4'(i));
        end
        applyStimulus(8'h78);
        checkOutput("max done", 32'(loadDone), 32'd1);
        checkOutput("max no error", 32'(loadError), 32'd0);
        checkOutput("max addr last", 32'(memAddr), 32'hF);

        // Timeout: error exactly TMO cycles after the last strobe.
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        sendPayload("tmo w0", 8'h11, 4'h0);
        errCycle = -1;
        for (int k = 1; k <= TMO + 5; k++) begin
            @(negedge clk);
            if (loadError && errCycle < 0) begin
                errCycle = k;
            end
        end
        checkOutput("tmo cycle", 32'(errCycle), 32'(TMO));
        checkOutput("tmo idle", 32'(busy), 32'd0);
        checkOutput("tmo halt", 32'(cpuHalt), 32'd1);
        sendGoodFrame("after tmo");

        // Reset in the middle of the payload.
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        sendPayload("rst w0", 8'h12, 4'h0);
        resetN = 1'b0;
        #1;
        checkOutput("midreset halt", 32'(cpuHalt), 32'd1);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset we", 32'(memWe), 32'd0);
        checkOutput("midreset addr", 32'(memAddr), 32'd0);
        checkOutput("midreset data", 32'(memData), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        sendGoodFrame("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
